// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer_if
//  Description : Bundle of raw switch inputs and the conditioned outputs
//                (level, rise/fall strobes, toggle) of switch_debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if #(
  parameter int NB_CH = 4
);
  logic [NB_CH-1:0] sw_in;
  logic [NB_CH-1:0] sw_level;
  logic [NB_CH-1:0] sw_rise;
  logic [NB_CH-1:0] sw_fall;
  logic [NB_CH-1:0] sw_toggle;

  // Pin side: drives the raw levels and observes the conditioned outputs
  modport master (
    output sw_in,
    input  sw_level,
    input  sw_rise,
    input  sw_fall,
    input  sw_toggle
  );

  // Debouncer side
  modport slave (
    input  sw_in,
    output sw_level,
    output sw_rise,
    output sw_fall,
    output sw_toggle
  );
endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : Per-channel 2-flop synchroniser followed by a hold-time
//                filter. A channel's level only changes after the
//                synchronised input has differed from it for DEBOUNCE_CYCLES
//                consecutive cycles. One-cycle rise/fall strobes accompany
//                each accepted change.
//                Optional feature macro: DEBOUNCE_TOGGLE_EN - adds a per
//                channel toggle flop that inverts after every rise strobe.
//                Without it sw_toggle is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
  parameter int NB_CH           = 4,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  switch_debouncer_if.slave  sw_bus
);

  // Counter must hold DEBOUNCE_CYCLES-1; sized one value larger for margin
  localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  logic [NB_CH-1:0]              sync1_q;
  logic [NB_CH-1:0]              sync2_q;
  logic [NB_CH-1:0]              level_q, level_d;
  logic [NB_CH-1:0]              rise_q,  rise_d;
  logic [NB_CH-1:0]              fall_q,  fall_d;
  logic [NB_CH-1:0][C_CNT_W-1:0] cnt_q,   cnt_d;

  // Per channel: count while the synchronised input disagrees with the
  // accepted level; accept the new level when the count completes
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = '0;
    for (int i = 0; i < NB_CH; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == C_CNT_LAST) begin
          // Change held long enough: accept it and strobe in the same cycle
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + C_CNT_ONE;
        end
      end
      // Matching input leaves cnt_d at 0, dropping any partial count
    end
  end

  // Synchroniser, filter counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_bus.sw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_bus.sw_level = level_q;
  assign sw_bus.sw_rise  = rise_q;
  assign sw_bus.sw_fall  = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
  logic [NB_CH-1:0] toggle_q, toggle_d;

  // Flip the latched state in the cycle following each rise strobe
  always_comb begin
    toggle_d = toggle_q ^ rise_q;
  end

  // Toggle state register
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign sw_bus.sw_toggle = toggle_q;
`else
  assign sw_bus.sw_toggle = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debouncer
//  Description : Directed self-checking bench for switch_debouncer with
//                NB_CH=4, DEBOUNCE_CYCLES=8 (latency 10 edges from input
//                step to level change).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

  localparam int NB_CH   = 4;
  localparam int DEB     = 8;
  localparam int LAT     = DEB + 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  switch_debouncer_if #(.NB_CH(NB_CH)) bus ();

  switch_debouncer #(
    .NB_CH           (NB_CH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later; rise and fall may never coincide
  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_overlap", 32'(bus.sw_rise & bus.sw_fall), 32'h0);
  endtask

  // Hold sw_in for n cycles, expecting a single strobe of `pat` at cycle LAT
  task automatic hold_expect(input string tag, input logic [3:0] val, input int n,
                             input logic [3:0] rise_pat, input logic [3:0] fall_pat,
                             input logic [3:0] lvl_before, input logic [3:0] lvl_after);
    bus.sw_in = val;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c < LAT) begin
        chk({tag, "_lvl_pre"}, 32'(bus.sw_level), 32'(lvl_before));
        chk({tag, "_strobe_pre"}, 32'({bus.sw_rise, bus.sw_fall}), 32'h0);
      end else if (c == LAT) begin
        chk({tag, "_lvl_at"}, 32'(bus.sw_level), 32'(lvl_after));
        chk({tag, "_rise_at"}, 32'(bus.sw_rise), 32'(rise_pat));
        chk({tag, "_fall_at"}, 32'(bus.sw_fall), 32'(fall_pat));
      end else begin
        chk({tag, "_lvl_post"}, 32'(bus.sw_level), 32'(lvl_after));
        chk({tag, "_strobe_post"}, 32'({bus.sw_rise, bus.sw_fall}), 32'h0);
      end
    end
  endtask

  logic [3:0] exp_tog;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.sw_in = 4'b0000;

    // 1. reset for 3 cycles, then 20 quiet cycles
    repeat (3) tick();
    chk("rst_level",  32'(bus.sw_level),  32'h0);
    chk("rst_rise",   32'(bus.sw_rise),   32'h0);
    chk("rst_fall",   32'(bus.sw_fall),   32'h0);
    chk("rst_toggle", 32'(bus.sw_toggle), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_outputs", 32'({bus.sw_level, bus.sw_rise, bus.sw_fall}), 32'h0);
    end

    // 2. ch0 step: level and rise exactly LAT edges later
    hold_expect("ch0_rise", 4'b0001, 14, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    // 3. 5-cycle glitch on ch1 must be rejected
    bus.sw_in = 4'b0011;
    repeat (5) begin
      tick();
      chk("glitch_lvl", 32'(bus.sw_level), 32'h1);
    end
    bus.sw_in = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk("glitch_lvl",    32'(bus.sw_level), 32'h1);
      chk("glitch_strobe", 32'({bus.sw_rise, bus.sw_fall}), 32'h0);
    end

    // Bring ch0 back low so every channel starts from 0
    hold_expect("ch0_fall", 4'b0000, 12, 4'b0000, 4'b0001, 4'b0001, 4'b0000);

    // 4. all channels together: rise, then fall 12 cycles later
    hold_expect("all_rise", 4'b1111, 12, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    hold_expect("all_fall", 4'b0000, 12, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

    // 5. reset while ch2 count is 5 (7 edges after the step), input held high
    bus.sw_in = 4'b0100;
    repeat (7) tick();
    chk("pre_rst_lvl", 32'(bus.sw_level), 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_rst_lvl",  32'(bus.sw_level), 32'h0);
    chk("mid_rst_rise", 32'(bus.sw_rise),  32'h0);
    rst = 1'b0;
    hold_expect("post_rst", 4'b0100, 12, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    hold_expect("ch2_fall", 4'b0000, 12, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    chk("tog_after_rst", 32'(bus.sw_toggle), 32'h0);

    // 6. three clean presses on ch3; toggle flips the cycle after each rise
    exp_tog = 4'b0000;
    for (int p = 0; p < 3; p++) begin
      bus.sw_in = 4'b1000;
      for (int c = 1; c <= 12; c++) begin
        tick();
`ifdef DEBOUNCE_TOGGLE_EN
        if (c == LAT + 1) exp_tog[3] = ~exp_tog[3];
`endif
        if (c == LAT) chk("press_rise", 32'(bus.sw_rise), 32'h8);
        chk("press_toggle", 32'(bus.sw_toggle), 32'(exp_tog));
      end
      bus.sw_in = 4'b0000;
      for (int c = 1; c <= 12; c++) begin
        tick();
        if (c == LAT) chk("release_fall", 32'(bus.sw_fall), 32'h8);
        chk("release_toggle", 32'(bus.sw_toggle), 32'(exp_tog));
      end
    end
`ifdef DEBOUNCE_TOGGLE_EN
    chk("toggle_final", 32'(bus.sw_toggle), 32'h8);
`else
    chk("toggle_final", 32'(bus.sw_toggle), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
